seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be asynchronous and active-high. Ports are listed below as name, direction, width, meaning.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 a  input  32  dividend.
REQ-006 b  input  32  divisor.
REQ-007 hi  output  32  registered remainder.
REQ-008 lo  output  32  registered quotient.
REQ-009 ready  output  1  one-cycle completion pulse.
REQ-010 div_zero  output  1  one-cycle divide-by-zero flag, coincident with ready.

Function
REQ-011 The FSM SHALL have states IDLE, CHECK, RUN, SIGN, DONE, with transitions as follows.
- IDLE->CHECK on start=1: latch a and b (magnitudes plus sign bits when signed).
- CHECK->DONE with div_zero=1 if the latched divisor is 0; otherwise CHECK->RUN with the iteration counter cleared.
- RUN->SIGN after exactly 32 iterations; SIGN->DONE; DONE->IDLE unconditionally.
REQ-012 RUN SHALL perform one restoring iteration per clock.
- Shift {remainder,quotient} left by 1.
- Trial-subtract the divisor from the 33-bit partial remainder.
- On non-negative result: keep it and set quotient LSB to 1; otherwise restore and set LSB to 0.
REQ-013 The edge sampling start is edge 0. ready SHALL be high during exactly the one cycle following edge 34 for a normal divide, and following edge 1 for divisor zero.
REQ-014 hi and lo SHALL be loaded only on the SIGN->DONE transition and held stable until the next successful completion.
- A divide-by-zero SHALL leave hi/lo unchanged.
REQ-015 start asserted in any state other than IDLE, including DONE, SHALL be ignored. No queuing.
REQ-016 a and b SHALL be sampled only at the IDLE->CHECK edge. Later changes to a and b SHALL have no effect on the operation in progress.
REQ-017 ready and div_zero SHALL be driven from registered state, not combinationally from inputs.

Reset
REQ-018 Reset SHALL force IDLE, hi=0, lo=0, ready=0, div_zero=0, counter=0, and all datapath registers to 0, asynchronously and at any point.
REQ-019 Reset asserted mid-operation SHALL abort the operation without any ready pulse.
- The first start after reset release SHALL complete with correct results.

Configuration
REQ-020 Macro SEQ_DIVIDER_SIGNED_EN defined: two's-complement signed division.
- Operands are converted to magnitudes in CHECK.
- In SIGN, the quotient is negated iff a[31]^b[31], and the remainder takes the sign of a.
- 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 with no flag.
REQ-021 Macro undefined: unsigned division only.
- SIGN SHALL pass results unchanged while still consuming its cycle, so latency is identical in both builds.

Structure
REQ-022 The shared package SHALL hold:
- the state enum for IDLE/CHECK/RUN/SIGN/DONE;
- DIV_WIDTH=32;
- DIV_ITERS=32;
- DIV_LATENCY=35 and DIVZ_LATENCY=2.
REQ-023 The combinational single-iteration shift/subtract/restore SHALL be one sub-module, div_restore_step, instantiated once in RUN's datapath. The FSM, counter and sign logic SHALL remain in seq_divider.

Verification
REQ-024 a=100, b=7, start pulse -> ready high one cycle after edge 34, lo=14, hi=2, div_zero=0.
REQ-025 Signed build, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned build, a=0xFFFFFFFF, b=2 -> lo=0x7FFFFFFF, hi=1.
REQ-026 After the REQ-024 result, a=5, b=0 -> ready=1 and div_zero=1 one cycle after edge 1, with hi=2 and lo=14 unchanged.
REQ-027 a=100, b=7, then start re-pulsed with a=9, b=3 at edge 10 and during DONE -> exactly one ready pulse, lo=14, hi=2.
REQ-028 Reset asserted at edge 15 of an operation -> outputs 0, no ready. Then a=0x80000000, b=0xFFFFFFFF (signed build) -> lo=0x80000000, hi=0 at edge 34.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants, state type and helpers for the sequential divider.
// Signed operation is enabled by defining SEQ_DIVIDER_SIGNED_EN.
package seq_divider_pkg;

   localparam int DIV_WIDTH    = 32;
   localparam int DIV_ITERS    = 32;
   localparam int DIV_LATENCY  = 35;
   localparam int DIVZ_LATENCY = 2;
   localparam int CNT_WIDTH    = $clog2(DIV_ITERS) + 1;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      RUN,
      SIGN,
      DONE
   } div_state_t;

   // Two's-complement negate when n is set.
   function automatic logic [DIV_WIDTH-1:0] neg_if(
      input logic [DIV_WIDTH-1:0] v,
      input logic                 n
   );
      return n ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration:
// shift {rem,quo} left, trial-subtract divisor, keep or restore.
module div_restore_step
   import seq_divider_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] i_rem,
   input  logic [DIV_WIDTH-1:0] i_quo,
   input  logic [DIV_WIDTH-1:0] i_dvs,
   output logic [DIV_WIDTH-1:0] o_rem,
   output logic [DIV_WIDTH-1:0] o_quo
);

   logic [DIV_WIDTH:0]   w_shift;
   logic [DIV_WIDTH-1:0] w_diff;
   logic                 w_fits;

   assign w_shift = {i_rem, i_quo[DIV_WIDTH-1]};
   assign w_fits  = (w_shift >= {1'b0, i_dvs});
   // Remainder stays below the divisor, so the low bits carry the full difference.
   assign w_diff  = w_shift[DIV_WIDTH-1:0] - i_dvs;

   always_comb begin
      o_rem = w_shift[DIV_WIDTH-1:0];
      o_quo = {i_quo[DIV_WIDTH-2:0], 1'b0};
      if (w_fits) begin
         o_rem = w_diff;
         o_quo = {i_quo[DIV_WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential 32-bit restoring divider: IDLE/CHECK/RUN/SIGN/DONE FSM.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement signed division.
module seq_divider
   import seq_divider_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] a,
   input  logic [DIV_WIDTH-1:0] b,
   output logic [DIV_WIDTH-1:0] hi,
   output logic [DIV_WIDTH-1:0] lo,
   output logic                 ready,
   output logic                 div_zero
);

   div_state_t           r_state;
   div_state_t           w_state_nxt;
   logic [DIV_WIDTH-1:0] r_a;
   logic [DIV_WIDTH-1:0] r_b;
   logic [DIV_WIDTH-1:0] r_rem;
   logic [DIV_WIDTH-1:0] r_quo;
   logic [DIV_WIDTH-1:0] r_dvs;
   logic [DIV_WIDTH-1:0] r_hi;
   logic [DIV_WIDTH-1:0] r_lo;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_dz;

   logic [DIV_WIDTH-1:0] w_step_rem;
   logic [DIV_WIDTH-1:0] w_step_quo;
   logic [DIV_WIDTH-1:0] w_a_mag;
   logic [DIV_WIDTH-1:0] w_b_mag;
   logic [DIV_WIDTH-1:0] w_hi_res;
   logic [DIV_WIDTH-1:0] w_lo_res;
   logic                 w_last;
   logic                 w_b_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic r_sa;
   logic r_sb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sa <= 1'b0;
         r_sb <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_sa <= a[DIV_WIDTH-1];
         r_sb <= b[DIV_WIDTH-1];
      end
   end

   // Quotient sign is the xor of operand signs; remainder follows the dividend.
   assign w_a_mag  = neg_if(r_a, r_sa);
   assign w_b_mag  = neg_if(r_b, r_sb);
   assign w_lo_res = neg_if(r_quo, r_sa ^ r_sb);
   assign w_hi_res = neg_if(r_rem, r_sa);
`else
   assign w_a_mag  = r_a;
   assign w_b_mag  = r_b;
   assign w_lo_res = r_quo;
   assign w_hi_res = r_rem;
`endif

   assign w_last   = (r_cnt == CNT_WIDTH'(DIV_ITERS - 1));
   assign w_b_zero = (r_b == '0);

   div_restore_step u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_dvs (r_dvs),
      .o_rem (w_step_rem),
      .o_quo (w_step_quo)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = CHECK;
         CHECK:   w_state_nxt = w_b_zero ? DONE : RUN;
         RUN:     if (w_last) w_state_nxt = SIGN;
         SIGN:    w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a   <= '0;
         r_b   <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_cnt <= '0;
         r_dz  <= 1'b0;
      end else begin
         r_dz <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_a <= a;
                  r_b <= b;
               end
            end
            CHECK: begin
               r_rem <= '0;
               r_quo <= w_a_mag;
               r_dvs <= w_b_mag;
               r_cnt <= '0;
               r_dz  <= w_b_zero;
            end
            RUN: begin
               r_rem <= w_step_rem;
               r_quo <= w_step_quo;
               r_cnt <= r_cnt + 1'b1;
            end
            SIGN: begin
               r_hi <= w_hi_res;
               r_lo <= w_lo_res;
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign ready    = (r_state == DONE);
   assign div_zero = r_dz;

endmodule
